// File: rtl/ethernet_receive_slot_scheduler.sv
// Receive slot scheduler: tracks FREE/FILLING/FULL/DRAINING per slot, offers the lowest
// free slot to the packet parser and hands full slots to one reader in round-robin order.
module ethernet_receive_slot_scheduler #(
    parameter int RECEIVE_QUE_SLOTS = 4
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [RECEIVE_QUE_SLOTS-1:0]           packet_data_valid,
    input  logic [RECEIVE_QUE_SLOTS-1:0]           good_packet,
    input  logic [RECEIVE_QUE_SLOTS-1:0]           bad_packet,
    input  logic                                   drain_ready,
    input  logic                                   drain_done,
    output logic [RECEIVE_QUE_SLOTS-1:0]           recieve_slot_enable,
    output logic [RECEIVE_QUE_SLOTS-1:0]           drain_grant,
    output logic                                   drain_valid,
    output logic [$clog2(RECEIVE_QUE_SLOTS+1)-1:0] free_count,
    output logic                                   protocol_error
);

    localparam int N     = RECEIVE_QUE_SLOTS;
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [N-1:0]     ONE_N    = {{(N-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        SLOT_FREE     = 2'd0,
        SLOT_FILLING  = 2'd1,
        SLOT_FULL     = 2'd2,
        SLOT_DRAINING = 2'd3
    } slot_state_t;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_GRANT     = 2'd1,
        S_WAIT_DONE = 2'd2
    } drain_state_t;

    slot_state_t        slot_state_r [N];
    slot_state_t        slot_next_s  [N];
    slot_state_t        slot_final_s [N];
    logic [N-1:0]       slot_err_s;
    logic [N-1:0]       full_mask_s;
    logic [N-1:0]       free_mask_s;
    drain_state_t       drain_state_r;
    drain_state_t       drain_state_next_s;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [IDX_W-1:0]   rr_ptr_next_s;
    logic [IDX_W-1:0]   drain_idx_r;
    logic [IDX_W-1:0]   drain_idx_next_s;
    logic [N-1:0]       grant_next_s;
    logic               done_err_s;
    logic [IDX_W:0]     pick_s;
    logic               pick_valid_s;
    logic [IDX_W-1:0]   pick_idx_s;

    function automatic logic [N-1:0] lowest_onehot(input logic [N-1:0] mask);
        return mask & (~mask + ONE_N);
    endfunction

    function automatic logic [CNT_W-1:0] count_ones(input logic [N-1:0] mask);
        logic [CNT_W-1:0] total;
        total = '0;
        for (int k = 0; k < N; k++) begin
            total = total + CNT_W'(mask[k]);
        end
        return total;
    endfunction

    // Scanning downward lets the candidate closest to the start pointer win.
    function automatic logic [IDX_W:0] rr_pick(input logic [N-1:0] mask,
                                               input logic [IDX_W-1:0] start);
        logic [IDX_W:0]   result;
        logic [IDX_W-1:0] cand;
        result = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(start) + i) % N);
            if (mask[cand]) begin
                result = {1'b1, cand};
            end
        end
        return result;
    endfunction

    assign pick_s       = rr_pick(full_mask_s, rr_ptr_r);
    assign pick_valid_s = pick_s[IDX_W];
    assign pick_idx_s   = pick_s[IDX_W-1:0];

    // Parser-side events: fill start, good and bad packet, with per-slot legality.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            slot_next_s[k] = slot_state_r[k];
            slot_err_s[k]  = 1'b0;
            case (slot_state_r[k])
                SLOT_FREE: begin
                    if (packet_data_valid[k] && recieve_slot_enable[k]) begin
                        slot_next_s[k] = SLOT_FILLING;
                    end else begin
                        slot_next_s[k] = SLOT_FREE;
                    end
                    slot_err_s[k] = (packet_data_valid[k] && !recieve_slot_enable[k])
                                    || good_packet[k] || bad_packet[k];
                end
                SLOT_FILLING: begin
                    if (bad_packet[k]) begin
                        slot_next_s[k] = SLOT_FREE;
                    end else if (good_packet[k]) begin
                        slot_next_s[k] = SLOT_FULL;
                    end else begin
                        slot_next_s[k] = SLOT_FILLING;
                    end
                    slot_err_s[k] = good_packet[k] && bad_packet[k];
                end
                SLOT_FULL: begin
                    slot_next_s[k] = SLOT_FULL;
                    slot_err_s[k]  = packet_data_valid[k] || good_packet[k] || bad_packet[k];
                end
                SLOT_DRAINING: begin
                    slot_next_s[k] = SLOT_DRAINING;
                    slot_err_s[k]  = packet_data_valid[k] || good_packet[k] || bad_packet[k];
                end
                default: begin
                    slot_next_s[k] = SLOT_FREE;
                    slot_err_s[k]  = 1'b0;
                end
            endcase
        end
    end

    // Slots that are FULL after this cycle's parser events are grant candidates.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            full_mask_s[k] = (slot_next_s[k] == SLOT_FULL);
        end
    end

    // Drain FSM next state; a grant claims its slot in the same cycle it is chosen.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            slot_final_s[k] = slot_next_s[k];
        end
        drain_state_next_s = drain_state_r;
        grant_next_s       = drain_grant;
        rr_ptr_next_s      = rr_ptr_r;
        drain_idx_next_s   = drain_idx_r;
        done_err_s         = 1'b0;
        case (drain_state_r)
            S_IDLE: begin
                done_err_s = drain_done;
                if (pick_valid_s) begin
                    slot_final_s[pick_idx_s] = SLOT_DRAINING;
                    grant_next_s             = ONE_N << pick_idx_s;
                    drain_idx_next_s         = pick_idx_s;
                    drain_state_next_s       = S_GRANT;
                    if (pick_idx_s == LAST_IDX) begin
                        rr_ptr_next_s = '0;
                    end else begin
                        rr_ptr_next_s = pick_idx_s + IDX_W'(1);
                    end
                end else begin
                    grant_next_s       = '0;
                    drain_state_next_s = S_IDLE;
                end
            end
            S_GRANT: begin
                if (drain_ready) begin
                    drain_state_next_s = S_WAIT_DONE;
                end else begin
                    drain_state_next_s = S_GRANT;
                    done_err_s         = drain_done;
                end
            end
            S_WAIT_DONE: begin
                if (drain_done) begin
                    slot_final_s[drain_idx_r] = SLOT_FREE;
                    grant_next_s              = '0;
                    drain_state_next_s        = S_IDLE;
                end else begin
                    drain_state_next_s = S_WAIT_DONE;
                end
            end
            default: begin
                grant_next_s       = '0;
                drain_state_next_s = S_IDLE;
            end
        endcase
    end

    // Free slots as they will stand after this cycle.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            free_mask_s[k] = (slot_final_s[k] == SLOT_FREE);
        end
    end

    // State and registered outputs, all derived from next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                slot_state_r[k] <= SLOT_FREE;
            end
            drain_state_r       <= S_IDLE;
            rr_ptr_r            <= '0;
            drain_idx_r         <= '0;
            recieve_slot_enable <= '0;
            drain_grant         <= '0;
            drain_valid         <= 1'b0;
            free_count          <= '0;
            protocol_error      <= 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                slot_state_r[k] <= slot_final_s[k];
            end
            drain_state_r       <= drain_state_next_s;
            rr_ptr_r            <= rr_ptr_next_s;
            drain_idx_r         <= drain_idx_next_s;
            recieve_slot_enable <= lowest_onehot(free_mask_s);
            drain_grant         <= grant_next_s;
            drain_valid         <= (drain_state_next_s == S_GRANT);
            free_count          <= count_ones(free_mask_s);
            protocol_error      <= (|slot_err_s) || done_err_s;
        end
    end

endmodule
